// File: rtl/scmp_bus_seq.sv
// External bus sequencer: arbitrates for the daisy-chained bus, then runs one
// address/strobe cycle with programmable wait states and hold extension.
module scmp_bus_seq #(
    parameter int AW   = 16,
    parameter int DW   = 8,
    parameter int FW   = 4,
    parameter int WMAX = 7,
    localparam int AB  = AW - (DW - FW),
    localparam int CW  = $clog2(WMAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_i,
    input  logic          req_we_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    input  logic [FW-1:0] req_flags_i,
    input  logic [CW-1:0] wait_cfg_i,
    output logic          ack_o,
    output logic [DW-1:0] rdata_o,
    output logic          busy_o,
    output logic [AB-1:0] addr_o,
    input  logic [DW-1:0] D_i,
    output logic [DW-1:0] D_o,
    output logic          D_oe,
    output logic          ADS_n,
    output logic          RD_n,
    output logic          WR_n,
    input  logic          hold_i,
    output logic          breq_o,
    input  logic          enin_i,
    output logic          enout_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_ADDR,
        S_STRB,
        S_DONE
    } state_t;

    state_t        state, state_nx;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [FW-1:0] flags_q;
    logic [CW-1:0] wait_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] rdata_q;
    logic [CW-1:0] wait_clamped;
    logic          strb_last;

    // Compare in int width so the clamp stays meaningful when WMAX+1 is not a power of two.
    assign wait_clamped = (int'(wait_cfg_i) > WMAX) ? CW'(WMAX) : wait_cfg_i;
    // hold_i only matters once the wait counter has run out.
    assign strb_last    = (state == S_STRB) && (cnt_q == '0) && !hold_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (req_i)     state_nx = S_ARB;
            S_ARB:   if (enin_i)    state_nx = S_ADDR;
            S_ADDR:                 state_nx = S_STRB;
            S_STRB:  if (strb_last) state_nx = S_DONE;
            S_DONE:                 state_nx = S_IDLE;
            default:                state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            flags_q <= '0;
            wait_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (state == S_IDLE && req_i) begin
                we_q    <= req_we_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                flags_q <= req_flags_i;
                wait_q  <= wait_clamped;
            end
            if (state == S_ADDR) begin
                cnt_q <= wait_q;
            end else if (state == S_STRB && cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (strb_last && !we_q) begin
                rdata_q <= D_i;
            end
        end
    end

    always_comb begin
        ADS_n  = 1'b1;
        RD_n   = 1'b1;
        WR_n   = 1'b1;
        D_oe   = 1'b0;
        D_o    = '0;
        breq_o = 1'b0;
        ack_o  = 1'b0;
        case (state)
            S_ARB: begin
                breq_o = 1'b1;
            end
            S_ADDR: begin
                breq_o = 1'b1;
                ADS_n  = 1'b0;
                D_oe   = 1'b1;
                D_o    = {flags_q, addr_q[AW-1:AB]};
            end
            S_STRB: begin
                breq_o = 1'b1;
                if (we_q) begin
                    WR_n = 1'b0;
                    D_oe = 1'b1;
                    D_o  = wdata_q;
                end else begin
                    RD_n = 1'b0;
                end
            end
            S_DONE: begin
                ack_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy_o  = (state != S_IDLE);
    assign enout_o = enin_i & ~breq_o;
    assign addr_o  = addr_q[AB-1:0];
    assign rdata_o = rdata_q;

endmodule

// File: doc/scmp_bus_seq.md
SCMP_BUS_SEQ -- requirements
Module: scmp_bus_seq

Interface
REQ-001 SHALL have parameter AW, default 16, full logical address width.
REQ-002 SHALL have parameter DW, default 8, data bus width.
REQ-003 SHALL have parameter FW, default 4, status-flag width; FW < DW and AW > DW-FW are required, with AB = AW-(DW-FW).
REQ-004 SHALL have parameter WMAX, default 7, maximum programmable wait states; CW = $clog2(WMAX+1).
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 req_i  in  1  core transaction request, level.
REQ-008 req_we_i  in  1  1 = write, 0 = read.
REQ-009 req_addr_i  in  AW  transaction address.
REQ-010 req_wdata_i  in  DW  write data.
REQ-011 req_flags_i  in  FW  status flags presented during the address phase.
REQ-012 wait_cfg_i  in  CW  wait-state count; values above WMAX are clamped to WMAX.
REQ-013 ack_o  out  1  one-cycle completion pulse.
REQ-014 rdata_o  out  DW  read data, held until the next read completes.
REQ-015 busy_o  out  1  high in any state other than IDLE.
REQ-016 addr_o  out  AB  low address bits; held from ADDR through STRB.
REQ-017 D_i  in  DW  external data in.
REQ-018 D_o  out  DW  external data out.
REQ-019 D_oe  out  1  external data drive enable.
REQ-020 ADS_n / RD_n / WR_n  out  1 each  active-low address strobe, read strobe and write strobe.
REQ-021 hold_i  in  1  external wait request; extends the strobe while high.
REQ-022 breq_o  out  1  bus request.
REQ-023 enin_i  in  1  bus grant in (daisy chain).
REQ-024 enout_o  out  1  grant out; equals enin_i & ~breq_o, combinational.

Function
REQ-025 SHALL implement the FSM IDLE -> ARB -> ADDR -> STRB -> DONE -> IDLE, one state per cycle except where stated.
REQ-026 IDLE: when req_i=1, SHALL latch req_we_i, req_addr_i, req_wdata_i, req_flags_i and the clamped wait_cfg_i, then go to ARB; the core need not hold these inputs after acceptance.
REQ-027 ARB: SHALL assert breq_o and stay in ARB while enin_i=0; when enin_i=1, SHALL go to ADDR.
REQ-028 ADDR (exactly 1 cycle): SHALL drive ADS_n=0, D_oe=1 and D_o={flags, addr[AW-1:AB]}; SHALL load the wait counter with the latched wait count.
REQ-029 STRB: SHALL drive RD_n=0 for reads, or WR_n=0 with D_oe=1 and D_o=wdata for writes.
REQ-030 STRB: while the counter is nonzero, SHALL decrement it each cycle; at zero with hold_i=1, SHALL stay in STRB; at zero with hold_i=0, SHALL go to DONE.
REQ-031 STRB exit, read: SHALL capture D_i into rdata_o on the final STRB cycle (counter=0, hold_i=0).
REQ-032 DONE (1 cycle): SHALL pulse ack_o=1, with all strobes high, D_oe=0 and breq_o=0; next state IDLE.
REQ-033 breq_o SHALL be 1 exactly in ARB, ADDR and STRB.
REQ-034 Latency: with enin_i=1, ack_o SHALL rise 4+W+H cycles after the cycle req_i is sampled, where W is the wait count and H is the number of extra hold cycles.
REQ-035 Once in ADDR, an enin_i drop SHALL NOT abort the transaction; it completes normally.
REQ-036 hold_i SHALL be ignored outside STRB, and ignored in STRB while the counter is nonzero.
REQ-037 A req_i still high in the IDLE cycle after DONE SHALL start a new transaction, giving back-to-back requests a 5-cycle minimum period.
REQ-038 ADS_n, RD_n and WR_n SHALL never be low simultaneously.
REQ-039 D_oe SHALL be 1 only in ADDR, and in STRB for writes.

Reset
REQ-040 rst_n=0 SHALL asynchronously force: state IDLE, ADS_n=RD_n=WR_n=1, D_oe=0, D_o=0, breq_o=0, ack_o=0, busy_o=0, addr_o=0, rdata_o=0, latched fields 0, counter 0.
REQ-041 A reset during any state SHALL abort the transaction with no ack_o; after release, the block SHALL idle until req_i is sampled high.

Verification
REQ-042 Read, wait_cfg=0, enin=1, addr=0xA123, flags=0x5, D_i=0x3C in STRB -> ADS_n low 1 cycle with D_o=0x5A and addr_o=0x123; RD_n low 1 cycle; ack 4 cycles after the request; rdata_o=0x3C.
REQ-043 Write, wait_cfg=2, wdata=0x99, hold_i=1 for 2 cycles after the counter reaches 0 -> WR_n low 5 cycles, D_o=0x99 throughout, ack once.
REQ-044 enin_i=0 for 6 cycles after the request -> breq_o=1 and enout_o=0 in ARB; ADS_n rises never during ARB; the transaction proceeds the cycle after enin_i=1.
REQ-045 wait_cfg_i=15 with WMAX=7 -> strobe length 8 cycles.
REQ-046 rst_n pulsed low mid-STRB -> all strobes high immediately, no ack_o, FSM in IDLE.
REQ-047 req_i held high across two transactions -> two ack_o pulses 5 cycles apart; enout_o=enin_i in the DONE and IDLE cycles.
